// File: rtl/mem_request_arbiter.sv
// ============================================================================
// Module   : mem_request_arbiter
// Purpose  : Arbitrates between the instruction-fetch port and the data port
//            for a single shared word-wide RAM port. One access is granted at
//            a time. The RAM handshake is sequenced here. Read data is
//            returned with per-port wait signals that stall the datapath.
//            Data accesses have priority, but a starvation limit guarantees
//            that instruction fetch still progresses. A watchdog aborts any
//            RAM access that never completes.
//
// Ports    :
//   CLK, nRST             clock (rising edge), synchronous active-low reset
//   iREN, iaddr           instruction read request / address
//   dREN, dWEN            data read / write request
//   daddr, dstore         data address / write value
//   iwait, dwait          low for one cycle when the matching access is done
//   iload, dload          returned instruction / loaded data
//   ram_ren, ram_wen      RAM read / write strobes
//   ram_addr, ram_store   RAM address / write data
//   ram_load, ram_ready   RAM read data / one-cycle completion pulse
//   bus_err               one-cycle pulse with wait low on watchdog abort
//
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_request_arbiter #(
    parameter int WORD_W          = 32,
    parameter int ADDR_W          = 32,
    parameter int MAX_DATA_GRANTS = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    // instruction port
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    // data port
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    // shared RAM port
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_store,
    input  logic [WORD_W-1:0] ram_load,
    input  logic              ram_ready,
    // error reporting
    output logic              bus_err
);

    // ------------------------------------------------------------------
    // Counter sizing
    // ------------------------------------------------------------------
    localparam int STARVE_W = $clog2(MAX_DATA_GRANTS + 1);
    localparam int TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_DATA_GRANTS);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_ACC  = 3'd1,
        I_ACC  = 3'd2,
        D_DONE = 3'd3,
        I_DONE = 3'd4
    } state_t;

    state_t              state;
    logic [STARVE_W-1:0] starve_cnt;
    logic [TMO_W-1:0]    tmo_cnt;

    // ------------------------------------------------------------------
    // Arbitration decision (only acted upon in IDLE)
    // ------------------------------------------------------------------
    logic data_req;
    logic data_win;
    logic instr_win;

    assign data_req  = dREN | dWEN;
    // Data keeps priority until it has won MAX_DATA_GRANTS times in a row
    // while a fetch was waiting; then the fetch gets the next slot.
    assign data_win  = data_req && (!iREN || (starve_cnt < STARVE_MAX));
    assign instr_win = iREN && !data_win;

    // ------------------------------------------------------------------
    // Sequencer: state, counters and all outputs are registered here.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            ram_ren    <= 1'b0;
            ram_wen    <= 1'b0;
            ram_addr   <= '0;
            ram_store  <= '0;
            iload      <= '0;
            dload      <= '0;
            iwait      <= 1'b1;
            dwait      <= 1'b1;
            bus_err    <= 1'b0;
        end else begin
            // The wait lines and bus_err are asserted only for the single
            // DONE cycle. They return to idle values unless overridden below.
            iwait   <= 1'b1;
            dwait   <= 1'b1;
            bus_err <= 1'b0;

            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (data_win) begin
                        ram_addr  <= daddr;
                        ram_store <= dstore;
                        // A write wins when both read and write are requested.
                        ram_wen   <= dWEN;
                        ram_ren   <= dREN & ~dWEN;
                        state     <= D_ACC;
                        if (iREN) begin
                            if (starve_cnt < STARVE_MAX) begin
                                starve_cnt <= starve_cnt + 1'b1;
                            end
                        end else begin
                            starve_cnt <= '0;
                        end
                    end else if (instr_win) begin
                        ram_addr   <= iaddr;
                        ram_ren    <= 1'b1;
                        ram_wen    <= 1'b0;
                        starve_cnt <= '0;
                        state      <= I_ACC;
                    end else begin
                        starve_cnt <= '0;
                    end
                end

                D_ACC, I_ACC: begin
                    // Strobes, address and store data stay as granted. Requester
                    // inputs are ignored until the access finishes.
                    if (ram_ready) begin
                        if (state == I_ACC) begin
                            iload <= ram_load;
                            iwait <= 1'b0;
                            state <= I_DONE;
                        end else begin
                            // ram_ren is still the granted strobe here, so it
                            // tells a read apart from a write.
                            if (ram_ren) begin
                                dload <= ram_load;
                            end
                            dwait <= 1'b0;
                            state <= D_DONE;
                        end
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Watchdog abort. Report completion with bus_err and
                        // leave the load registers untouched.
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                        tmo_cnt <= '0;
                        bus_err <= 1'b1;
                        if (state == I_ACC) begin
                            iwait <= 1'b0;
                            state <= I_DONE;
                        end else begin
                            dwait <= 1'b0;
                            state <= D_DONE;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                D_DONE, I_DONE: begin
                    // Exactly one cycle. Back-to-back requests are re-arbitrated
                    // in IDLE, never bypassed from here.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_request_arbiter.sv
// ============================================================================
// Module   : tb_mem_request_arbiter
// Purpose  : Self-checking bench for mem_request_arbiter. It runs directed
//            scenarios and then a randomized run, which is checked against a
//            transaction-level model of grant order, latency and returned data.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_request_arbiter;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;
    localparam int MAXG   = 4;
    localparam int TMO    = 64;

    logic              CLK       = 1'b0;
    logic              nRST      = 1'b0;
    logic              iREN      = 1'b0;
    logic [ADDR_W-1:0] iaddr     = '0;
    logic              dREN      = 1'b0;
    logic              dWEN      = 1'b0;
    logic [ADDR_W-1:0] daddr     = '0;
    logic [WORD_W-1:0] dstore    = '0;
    logic [WORD_W-1:0] ram_load  = '0;
    logic              ram_ready = 1'b0;

    logic              iwait, dwait, bus_err;
    logic [WORD_W-1:0] iload, dload, ram_store;
    logic              ram_ren, ram_wen;
    logic [ADDR_W-1:0] ram_addr;

    int n_cmp = 0;
    int n_err = 0;

    // Model of the values the load registers must hold.
    logic [WORD_W-1:0] exp_iload = '0;
    logic [WORD_W-1:0] exp_dload = '0;

    always #5 CLK = ~CLK;

    mem_request_arbiter #(
        .WORD_W(WORD_W), .ADDR_W(ADDR_W),
        .MAX_DATA_GRANTS(MAXG), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready),
        .bus_err(bus_err)
    );

    task automatic tick();
        @(negedge CLK);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [2*WORD_W+ADDR_W+4:0] got;
        logic [2*WORD_W+ADDR_W+4:0] exp;
        exp = {1'b0, 1'b0, {ADDR_W{1'b0}}, 1'b1, 1'b1, 1'b0, {WORD_W{1'b0}}, {WORD_W{1'b0}}};
        nRST = 1'b0;
        tick(); tick();
        got = {ram_ren, ram_wen, ram_addr, iwait, dwait, bus_err, iload, dload};
        n_cmp++;
        if (got !== exp) begin
            n_err++; $display("FAIL reset_state: got %h expected %h", got, exp);
        end
        n_cmp++;
        if (ram_store !== '0) begin
            n_err++; $display("FAIL reset_store: got %h expected 0", ram_store);
        end
        // Enter D_ACC, then reset during the access.
        nRST = 1'b1; dREN = 1'b1; daddr = 32'h55;
        tick();
        n_cmp++;
        if ({ram_ren, ram_addr} !== {1'b1, 32'h55}) begin
            n_err++; $display("FAIL reset_pre_acc: got %b/%h expected 1/55", ram_ren, ram_addr);
        end
        nRST = 1'b0; dREN = 1'b0;
        tick(); tick();
        got = {ram_ren, ram_wen, ram_addr, iwait, dwait, bus_err, iload, dload};
        n_cmp++;
        if (got !== exp) begin
            n_err++; $display("FAIL reset_in_flight: got %h expected %h", got, exp);
        end
        // A late ram_ready must not produce a completion for the aborted access.
        nRST = 1'b1; ram_ready = 1'b1; ram_load = 32'hFFFF0000;
        tick();
        ram_ready = 1'b0;
        tick();
        n_cmp++;
        if ({dwait, iwait, bus_err, dload} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
            n_err++; $display("FAIL reset_no_completion: got %b%b%b %h expected 110 0",
                              dwait, iwait, bus_err, dload);
        end
        exp_iload = '0; exp_dload = '0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_read();
        int held = 0;
        iREN = 1'b1; iaddr = 32'h40;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (ram_ren && !ram_wen && ram_addr == 32'h40 && iwait) held++;
            if (k == 3) begin ram_ready = 1'b1; ram_load = 32'h8C220004; end
        end
        n_cmp++;
        if (held != 3) begin
            n_err++; $display("FAIL single_read_strobe: got %0d cycles expected 3", held);
        end
        tick();
        ram_ready = 1'b0; iREN = 1'b0;
        exp_iload = 32'h8C220004;
        n_cmp++;
        if ({iwait, dwait, bus_err, ram_ren, iload} !== {1'b0, 1'b1, 1'b0, 1'b0, exp_iload}) begin
            n_err++; $display("FAIL single_read_done: got %b%b%b%b %h expected 0100 %h",
                              iwait, dwait, bus_err, ram_ren, iload, exp_iload);
        end
        tick();
        n_cmp++;
        if ({iwait, dwait} !== 2'b11) begin
            n_err++; $display("FAIL single_read_idle: got %b%b expected 11", iwait, dwait);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_write_priority();
        iREN = 1'b1; iaddr = 32'h200;
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        tick();                                   // cycle 1: D_ACC
        n_cmp++;
        if ({ram_wen, ram_ren, ram_addr, ram_store} !== {1'b1, 1'b0, 32'h100, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL wr_prio_grant: got %b%b %h %h expected 10 100 deadbeef",
                              ram_wen, ram_ren, ram_addr, ram_store);
        end
        ram_ready = 1'b1; ram_load = 32'h13572468;
        tick();                                   // cycle 2: D_DONE
        ram_ready = 1'b0; dWEN = 1'b0;
        n_cmp++;
        if ({dwait, iwait, dload} !== {1'b0, 1'b1, exp_dload}) begin
            n_err++; $display("FAIL wr_prio_done: got %b%b %h expected 01 %h",
                              dwait, iwait, dload, exp_dload);
        end
        tick();                                   // cycle 3: IDLE, grants fetch
        tick();                                   // cycle 4: I_ACC
        n_cmp++;
        if ({ram_ren, ram_wen, ram_addr} !== {1'b1, 1'b0, 32'h200}) begin
            n_err++; $display("FAIL wr_prio_instr: got %b%b %h expected 10 200",
                              ram_ren, ram_wen, ram_addr);
        end
        ram_ready = 1'b1; ram_load = 32'h11111111;
        tick();
        ram_ready = 1'b0; iREN = 1'b0;
        exp_iload = 32'h11111111;
        n_cmp++;
        if ({iwait, iload} !== {1'b0, exp_iload}) begin
            n_err++; $display("FAIL wr_prio_instr_done: got %b %h expected 0 %h", iwait, iload, exp_iload);
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    // Two starvation windows in a row show that the counter restarts from
    // zero after each instruction grant.
    task automatic test_starvation();
        string order_exp = "DDDDIDDDDI";
        string order_got = "";
        int dcnt = 0;
        int icnt = 0;
        logic [WORD_W-1:0] val;
        iREN = 1'b1; iaddr = 32'h300;
        dREN = 1'b1; daddr = 32'h1000;
        for (int g = 0; g < 10; g++) begin
            tick();
            val = 32'hA0000000 + 32'(g);
            ram_ready = 1'b1; ram_load = val;
            if (ram_addr[15:12] == 4'h1) order_got = {order_got, "D"};
            else order_got = {order_got, "I"};
            tick();
            ram_ready = 1'b0;
            if (!dwait) begin
                exp_dload = val; dcnt++;
                if (dcnt == 8) dREN = 1'b0;
                else daddr = 32'h1000 + 32'(4 * dcnt);
            end else if (!iwait) begin
                exp_iload = val; icnt++;
                if (icnt == 2) iREN = 1'b0;
                else iaddr = 32'h304;
            end
            tick();
        end
        n_cmp++;
        if (order_got != order_exp) begin
            n_err++; $display("FAIL starvation_order: got %s expected %s", order_got, order_exp);
        end
        n_cmp++;
        if ({iload, dload} !== {exp_iload, exp_dload}) begin
            n_err++; $display("FAIL starvation_data: got %h %h expected %h %h",
                              iload, dload, exp_iload, exp_dload);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_timeout();
        int held = 0;
        dREN = 1'b1; daddr = 32'h80;
        for (int k = 1; k <= TMO; k++) begin
            tick();
            if (ram_ren && !ram_wen && ram_addr == 32'h80 && dwait && !bus_err) held++;
        end
        n_cmp++;
        if (held != TMO) begin
            n_err++; $display("FAIL timeout_hold: got %0d cycles expected %0d", held, TMO);
        end
        tick();
        dREN = 1'b0;
        n_cmp++;
        if ({dwait, bus_err, ram_ren, iwait, dload} !== {1'b0, 1'b1, 1'b0, 1'b1, exp_dload}) begin
            n_err++; $display("FAIL timeout_abort: got %b%b%b%b %h expected 0101 %h",
                              dwait, bus_err, ram_ren, iwait, dload, exp_dload);
        end
        tick();
        n_cmp++;
        if ({dwait, bus_err} !== 2'b10) begin
            n_err++; $display("FAIL timeout_idle: got %b%b expected 10", dwait, bus_err);
        end
        // ram_ready in the last allowed cycle completes normally.
        dREN = 1'b1; daddr = 32'h84; held = 0;
        for (int k = 1; k <= TMO; k++) begin
            tick();
            if (ram_ren && dwait) held++;
            if (k == TMO) begin ram_ready = 1'b1; ram_load = 32'h5A5A5A5A; end
        end
        tick();
        ram_ready = 1'b0; dREN = 1'b0;
        exp_dload = 32'h5A5A5A5A;
        n_cmp++;
        if ({held == TMO, dwait, bus_err, dload} !== {1'b1, 1'b0, 1'b0, exp_dload}) begin
            n_err++; $display("FAIL timeout_edge: got held=%0d %b%b %h expected %0d 00 %h",
                              held, dwait, bus_err, dload, TMO, exp_dload);
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_both_rw();
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h44; dstore = 32'h12345678;
        tick();
        n_cmp++;
        if ({ram_wen, ram_ren, ram_addr, ram_store} !== {1'b1, 1'b0, 32'h44, 32'h12345678}) begin
            n_err++; $display("FAIL both_rw_strobe: got %b%b %h %h expected 10 44 12345678",
                              ram_wen, ram_ren, ram_addr, ram_store);
        end
        ram_ready = 1'b1; ram_load = 32'hFFFFFFFF;
        tick();
        ram_ready = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        n_cmp++;
        if ({dwait, dload} !== {1'b0, exp_dload}) begin
            n_err++; $display("FAIL both_rw_done: got %b %h expected 0 %h", dwait, dload, exp_dload);
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    // Randomized requests and RAM latency against a transaction-level model.
    task automatic test_random();
        bit                i_pend = 0;
        bit                d_pend = 0;
        int                starve = 0;
        int                kind   = 0;     // 0 read, 1 write, 2 read+write
        int                lat;
        bit                win_d;
        logic [ADDR_W-1:0] ia = '0;
        logic [ADDR_W-1:0] da = '0;
        logic [WORD_W-1:0] ds = '0;
        logic [WORD_W-1:0] rd = '0;
        logic [ADDR_W-1:0] e_addr;
        logic              e_ren, e_wen;
        for (int r = 0; r < 120; r++) begin
            if (!i_pend && $urandom_range(0, 2) != 0) begin i_pend = 1; ia = $urandom; end
            if (!d_pend && $urandom_range(0, 2) != 0) begin
                d_pend = 1; da = $urandom; ds = $urandom; kind = $urandom_range(0, 2);
            end
            iREN = i_pend; iaddr = ia;
            dREN = d_pend && (kind != 1); dWEN = d_pend && (kind != 0);
            daddr = da; dstore = ds;
            ram_ready = 1'($urandom_range(0, 1)); ram_load = $urandom;
            if (!i_pend && !d_pend) begin
                starve = 0;
                tick();
                continue;
            end
            win_d = d_pend && (!i_pend || starve < MAXG);
            if (win_d && i_pend) starve = (starve < MAXG) ? starve + 1 : starve;
            else starve = 0;
            e_ren  = win_d ? (kind == 0) : 1'b1;
            e_wen  = win_d ? (kind != 0) : 1'b0;
            e_addr = win_d ? da : ia;
            lat = $urandom_range(1, 5);
            for (int k = 1; k <= lat; k++) begin
                tick();
                n_cmp++;
                if ({ram_ren, ram_wen, ram_addr, iwait, dwait} !== {e_ren, e_wen, e_addr, 1'b1, 1'b1} ||
                    (win_d && ram_store !== ds)) begin
                    n_err++; $display("FAIL rand_acc r=%0d k=%0d: got %b%b %h %h expected %b%b %h %h",
                                      r, k, ram_ren, ram_wen, ram_addr, ram_store, e_ren, e_wen, e_addr, ds);
                end
                // Inputs of the port in flight change; the access must not.
                if (win_d) begin daddr = $urandom; dstore = $urandom; end
                else iaddr = $urandom;
                ram_ready = (k == lat); ram_load = $urandom; rd = ram_load;
            end
            tick();
            if (win_d) begin if (kind == 0) exp_dload = rd; end
            else exp_iload = rd;
            n_cmp++;
            if ({iwait, dwait, bus_err, ram_ren, ram_wen, iload, dload} !==
                {win_d, !win_d, 1'b0, 1'b0, 1'b0, exp_iload, exp_dload}) begin
                n_err++; $display("FAIL rand_done r=%0d: got %b%b%b%b%b %h %h expected %b%b000 %h %h",
                                  r, iwait, dwait, bus_err, ram_ren, ram_wen, iload, dload,
                                  win_d, !win_d, exp_iload, exp_dload);
            end
            ram_ready = 1'($urandom_range(0, 1)); ram_load = $urandom;
            if (win_d) begin d_pend = 0; dREN = 1'b0; dWEN = 1'b0; end
            else begin i_pend = 0; iREN = 1'b0; end
            tick();
            n_cmp++;
            if ({iwait, dwait, ram_ren, ram_wen} !== 4'b1100) begin
                n_err++; $display("FAIL rand_idle r=%0d: got %b%b%b%b expected 1100",
                                  r, iwait, dwait, ram_ren, ram_wen);
            end
        end
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_priority();
        test_starvation();
        test_timeout();
        test_both_rw();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
